rx_fsm: RTL and testbench

- UART receive engine, mirror of the transmit FSM: recovers serial frames (start, 5–8 data bits LSB-first, optional parity, 1 or 2 stop bits) from `rx_in`.
- Uses an oversampling tick from the baud generator.
- Pushes each good character into the RX buffer.
- Reports parity, framing and overrun errors to the APB register block.

---
 rtl/rx_fsm_if.sv | 34 +++
 rtl/rx_fsm.sv | 199 +++++++++++++++++++
 tb/tb_rx_fsm.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_fsm_if.sv
// RX engine to RX buffer / register block bundle.
// Write strobe, received data and one-cycle status pulses.
interface rx_fsm_if;
  logic [7:0] rx_data;
  logic       ctrl_rx_buffer;
  logic       rx_buffer_full;
  logic       done_rx;
  logic       parity_error;
  logic       framing_error;
  logic       overrun_error;
  logic       break_detect;

  modport master (
    output rx_data,
    output ctrl_rx_buffer,
    output done_rx,
    output parity_error,
    output framing_error,
    output overrun_error,
    output break_detect,
    input  rx_buffer_full
  );

  modport slave (
    input  rx_data,
    input  ctrl_rx_buffer,
    input  done_rx,
    input  parity_error,
    input  framing_error,
    input  overrun_error,
    input  break_detect,
    output rx_buffer_full
  );
endinterface

// File: rtl/rx_fsm.sv
// UART receive FSM: oversampled start/data/parity/stop recovery.
// Optional break detection enabled by defining RX_BREAK_DETECT_EN.
module rx_fsm #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic       RXen,
  input  logic [3:0] number_data_trans,
  input  logic       parity_bit_mode,
  input  logic       parity_odd,
  input  logic       stop_bit_twice,
  output logic [3:0] bit_index,
  output logic       busy,
  rx_fsm_if.master   rxb
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP0  = 3'd4;
  localparam logic [2:0] S_STOP1  = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [2:0]             state;
  logic [TW-1:0]          tick_cnt;
  logic [3:0]             bit_cnt;
  logic [2:0]             n_last;
  logic [2:0]             nb_last;
  logic                   c_par;
  logic                   c_odd;
  logic                   c_two;
  logic                   par_acc;
  logic                   par_err;
  logic [7:0]             data_sh;
  logic                   tick_hit;
  logic                   counting;
  logic                   brk_hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_s = sync[SYNC_STAGES-1];

  always_comb begin
    nb_last = 3'(number_data_trans - 4'd1);
    unique case (1'b1)
      (number_data_trans < 4'd5): nb_last = 3'd4;
      (number_data_trans > 4'd8): nb_last = 3'd7;
      default: ;
    endcase
  end

  assign tick_hit = sample_tick &&
    ((state == S_START) ? (tick_cnt == T_MID)
                        : (tick_cnt == T_END));
  assign counting = (state != S_IDLE) && (state != S_COMMIT);
  assign busy      = (state != S_IDLE);
  assign bit_index = (state == S_DATA) ? bit_cnt : 4'd0;

`ifdef RX_BREAK_DETECT_EN
  logic zero_f;

  // Cleared by any 1 seen in data or parity samples.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      zero_f <= 1'b0;
    else if (state == S_IDLE)
      zero_f <= 1'b1;
    else if (tick_hit && rx_s &&
             (state == S_DATA || state == S_PARITY))
      zero_f <= 1'b0;
  end

  assign brk_hit = zero_f && (state == S_STOP0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rxb.break_detect <= 1'b0;
    else rxb.break_detect <= RXen && tick_hit && !rx_s && brk_hit;
  end
`else
  assign brk_hit          = 1'b0;
  assign rxb.break_detect = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state              <= S_IDLE;
      tick_cnt           <= '0;
      bit_cnt            <= '0;
      n_last             <= '0;
      c_par              <= 1'b0;
      c_odd              <= 1'b0;
      c_two              <= 1'b0;
      par_acc            <= 1'b0;
      par_err            <= 1'b0;
      data_sh            <= '0;
      rxb.rx_data        <= '0;
      rxb.ctrl_rx_buffer <= 1'b0;
      rxb.done_rx        <= 1'b0;
      rxb.parity_error   <= 1'b0;
      rxb.framing_error  <= 1'b0;
      rxb.overrun_error  <= 1'b0;
    end else begin
      rxb.ctrl_rx_buffer <= 1'b0;
      rxb.done_rx        <= 1'b0;
      rxb.parity_error   <= 1'b0;
      rxb.framing_error  <= 1'b0;
      rxb.overrun_error  <= 1'b0;
      if (!RXen) begin
        state    <= S_IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        par_acc  <= 1'b0;
        par_err  <= 1'b0;
      end else begin
        // ERROR restarts its idle-line count on any low sample.
        if (sample_tick && counting)
          tick_cnt <= (tick_hit || (state == S_ERROR && !rx_s))
                      ? '0 : tick_cnt + 1'b1;
        case (state)
          S_IDLE: begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            if (!rx_s) begin
              state  <= S_START;
              n_last <= nb_last;
              c_par  <= parity_bit_mode;
              c_odd  <= parity_odd;
              c_two  <= stop_bit_twice;
            end
          end
          S_START: if (tick_hit) begin
            if (rx_s) state <= S_IDLE;
            else begin
              state   <= S_DATA;
              bit_cnt <= '0;
              par_acc <= 1'b0;
              par_err <= 1'b0;
              data_sh <= '0;
            end
          end
          S_DATA: if (tick_hit) begin
            data_sh[bit_cnt[2:0]] <= rx_s;
            par_acc <= par_acc ^ rx_s;
            if (bit_cnt == {1'b0, n_last}) begin
              bit_cnt <= '0;
              state   <= c_par ? S_PARITY : S_STOP0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_PARITY: if (tick_hit) begin
            par_err <= ((par_acc ^ rx_s) != c_odd);
            state   <= S_STOP0;
          end
          S_STOP0, S_STOP1: if (tick_hit) begin
            if (!rx_s) begin
              state             <= S_ERROR;
              rxb.done_rx       <= 1'b1;
              rxb.framing_error <= !brk_hit;
              rxb.parity_error  <= par_err;
            end else if (state == S_STOP0 && c_two) begin
              state <= S_STOP1;
            end else begin
              state       <= S_COMMIT;
              rxb.done_rx <= 1'b1;
              if (par_err)
                rxb.parity_error <= 1'b1;
              else if (rxb.rx_buffer_full)
                rxb.overrun_error <= 1'b1;
              else begin
                rxb.ctrl_rx_buffer <= 1'b1;
                rxb.rx_data        <= data_sh;
              end
            end
          end
          S_COMMIT: state <= S_IDLE;
          S_ERROR: if (tick_hit && rx_s) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_fsm.sv
// Directed bench for rx_fsm: frames, errors, glitch, enable drop.
// Pulse counters are sampled on the falling edge.
module tb_rx_fsm;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       rx_in = 1'b1;
  logic       RXen = 1'b0;
  logic [3:0] number_data_trans = 4'd8;
  logic       parity_bit_mode = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop_bit_twice = 1'b0;
  logic [3:0] bit_index;
  logic       busy;
  logic       sample_tick;
  logic       half_rate = 1'b0;
  logic       tph = 1'b0;
  int         bc = 16;
  int         errs = 0;
  int         checks = 0;

  int         n_wr = 0, n_done = 0, n_perr = 0;
  int         n_ferr = 0, n_oerr = 0, n_brk = 0;
  logic [7:0] last_wr = 8'h00;

`ifdef RX_BREAK_DETECT_EN
  localparam int BRK_EXP = 1;
`else
  localparam int BRK_EXP = 0;
`endif

  rx_fsm_if bus ();

  rx_fsm #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .sample_tick       (sample_tick),
    .rx_in             (rx_in),
    .RXen              (RXen),
    .number_data_trans (number_data_trans),
    .parity_bit_mode   (parity_bit_mode),
    .parity_odd        (parity_odd),
    .stop_bit_twice    (stop_bit_twice),
    .bit_index         (bit_index),
    .busy              (busy),
    .rxb               (bus.master)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) tph <= ~tph;
  assign sample_tick = half_rate ? tph : 1'b1;

  always @(negedge PCLK) begin
    if (bus.ctrl_rx_buffer) begin
      n_wr    <= n_wr + 1;
      last_wr <= bus.rx_data;
    end
    if (bus.done_rx)       n_done <= n_done + 1;
    if (bus.parity_error)  n_perr <= n_perr + 1;
    if (bus.framing_error) n_ferr <= n_ferr + 1;
    if (bus.overrun_error) n_oerr <= n_oerr + 1;
    if (bus.break_detect)  n_brk  <= n_brk + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    idle(bc);
  endtask

  task automatic send(input logic [7:0] d, input int nb,
                      input bit pen, input bit pval,
                      input int nstop, input bit s0);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pval);
    drive_bit(s0);
    for (int i = 1; i < nstop; i++) drive_bit(1'b1);
    rx_in = 1'b1;
  endtask

  task automatic cfg(input logic [3:0] n, input bit pen,
                     input bit podd, input bit two);
    number_data_trans = n;
    parity_bit_mode   = pen;
    parity_odd        = podd;
    stop_bit_twice    = two;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    RXen = 1'b1;
    bus.rx_buffer_full = 1'b0;
    rx_in = 1'b0;
    idle(4);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (bit_index !== 4'd0) begin
      errs++; $display("FAIL reset_bit_index: got %0d want 0", bit_index);
    end
    checks++;
    if (bus.rx_data !== 8'h00) begin
      errs++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
    end
    checks++;
    if ({bus.ctrl_rx_buffer, bus.done_rx, bus.parity_error,
         bus.framing_error, bus.overrun_error,
         bus.break_detect} !== 6'b0) begin
      errs++; $display("FAIL reset_pulses: got nonzero want 0");
    end
    rx_in = 1'b1;
    idle(4);
    PRESETn = 1'b1;
    idle(4);
  endtask

  task automatic test_8n1;
    int w0 = n_wr, d0 = n_done;
    int e0 = n_perr + n_ferr + n_oerr;
    cfg(4'd8, 0, 0, 0);
    send(8'hA5, 8, 0, 0, 1, 1);
    idle(4);
    checks++;
    if (n_wr - w0 !== 1) begin
      errs++; $display("FAIL 8n1_writes: got %0d want 1", n_wr - w0);
    end
    checks++;
    if (last_wr !== 8'hA5) begin
      errs++; $display("FAIL 8n1_data: got %h want a5", last_wr);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      errs++; $display("FAIL 8n1_done: got %0d want 1", n_done - d0);
    end
    checks++;
    if (n_perr + n_ferr + n_oerr - e0 !== 0) begin
      errs++; $display("FAIL 8n1_errors: got %0d want 0",
                       n_perr + n_ferr + n_oerr - e0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL 8n1_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_parity;
    int w0 = n_wr, p0 = n_perr, d0;
    cfg(4'd5, 1, 0, 1);
    send(8'h1B, 5, 1, 1'b0, 2, 1);
    idle(4);
    checks++;
    if (n_wr - w0 !== 1 || last_wr !== 8'h1B) begin
      errs++; $display("FAIL par_good: got n=%0d d=%h want n=1 d=1b",
                       n_wr - w0, last_wr);
    end
    checks++;
    if (n_perr - p0 !== 0) begin
      errs++; $display("FAIL par_good_perr: got %0d want 0", n_perr - p0);
    end
    w0 = n_wr; p0 = n_perr; d0 = n_done;
    send(8'h1B, 5, 1, 1'b1, 2, 1);
    idle(4);
    checks++;
    if (n_perr - p0 !== 1) begin
      errs++; $display("FAIL par_bad_perr: got %0d want 1", n_perr - p0);
    end
    checks++;
    if (n_wr - w0 !== 0) begin
      errs++; $display("FAIL par_bad_write: got %0d want 0", n_wr - w0);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      errs++; $display("FAIL par_bad_done: got %0d want 1", n_done - d0);
    end
    checks++;
    if (bus.rx_data !== 8'h1B) begin
      errs++; $display("FAIL par_bad_hold: got %h want 1b", bus.rx_data);
    end
  endtask

  task automatic test_framing;
    int w0 = n_wr, f0 = n_ferr, d0 = n_done, p0 = n_perr;
    cfg(4'd7, 1, 1, 0);
    send(8'h41, 7, 1, 1'b1, 1, 0);
    idle(8);
    checks++;
    if (n_ferr - f0 !== 1 || n_wr - w0 !== 0) begin
      errs++; $display("FAIL frm_error: got f=%0d w=%0d want f=1 w=0",
                       n_ferr - f0, n_wr - w0);
    end
    checks++;
    if (n_done - d0 !== 1 || n_perr - p0 !== 0) begin
      errs++; $display("FAIL frm_done: got d=%0d p=%0d want d=1 p=0",
                       n_done - d0, n_perr - p0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL frm_wait_busy: got %b want 1", busy);
    end
    idle(30);
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL frm_idle_busy: got %b want 0", busy);
    end
    w0 = n_wr;
    send(8'h42, 7, 1, 1'b1, 1, 1);
    idle(4);
    checks++;
    if (n_wr - w0 !== 1 || last_wr !== 8'h42) begin
      errs++; $display("FAIL frm_next: got n=%0d d=%h want n=1 d=42",
                       n_wr - w0, last_wr);
    end
  endtask

  task automatic test_glitch;
    int d0 = n_done;
    cfg(4'd8, 0, 0, 0);
    rx_in = 1'b0;
    idle(4);
    checks++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL glitch_start: got %b want 1", busy);
    end
    idle(2);
    rx_in = 1'b1;
    idle(30);
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL glitch_busy: got %b want 0", busy);
    end
    checks++;
    if (n_done - d0 !== 0) begin
      errs++; $display("FAIL glitch_done: got %0d want 0", n_done - d0);
    end
  endtask

  task automatic test_overrun;
    int w0 = n_wr, o0 = n_oerr, d0 = n_done;
    cfg(4'd8, 0, 0, 0);
    bus.rx_buffer_full = 1'b1;
    send(8'h3C, 8, 0, 0, 1, 1);
    idle(4);
    bus.rx_buffer_full = 1'b0;
    checks++;
    if (n_oerr - o0 !== 1) begin
      errs++; $display("FAIL ovr_error: got %0d want 1", n_oerr - o0);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      errs++; $display("FAIL ovr_done: got %0d want 1", n_done - d0);
    end
    checks++;
    if (n_wr - w0 !== 0) begin
      errs++; $display("FAIL ovr_write: got %0d want 0", n_wr - w0);
    end
    checks++;
    if (bus.rx_data !== 8'h42) begin
      errs++; $display("FAIL ovr_hold: got %h want 42", bus.rx_data);
    end
  endtask

  task automatic test_rxen_drop;
    logic [7:0] d = 8'h96;
    int w0 = n_wr, d0 = n_done;
    int e0 = n_perr + n_ferr + n_oerr;
    cfg(4'd8, 0, 0, 0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_in = d[3];
    idle(8);
    checks++;
    if (bit_index !== 4'd3) begin
      errs++; $display("FAIL rxen_bit_index: got %0d want 3", bit_index);
    end
    RXen = 1'b0;
    rx_in = 1'b1;
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rxen_busy: got %b want 0", busy);
    end
    idle(150);
    checks++;
    if (n_wr - w0 !== 0 || n_done - d0 !== 0 ||
        n_perr + n_ferr + n_oerr - e0 !== 0) begin
      errs++; $display("FAIL rxen_pulses: got w=%0d d=%0d want 0",
                       n_wr - w0, n_done - d0);
    end
    RXen = 1'b1;
    idle(4);
  endtask

  task automatic test_break;
    int f0 = n_ferr, b0 = n_brk, d0 = n_done, w0 = n_wr;
    cfg(4'd8, 0, 0, 0);
    send(8'h00, 8, 0, 0, 1, 0);
    idle(40);
    checks++;
    if (n_brk - b0 !== BRK_EXP) begin
      errs++; $display("FAIL brk_detect: got %0d want %0d",
                       n_brk - b0, BRK_EXP);
    end
    checks++;
    if (n_ferr - f0 !== 1 - BRK_EXP) begin
      errs++; $display("FAIL brk_ferr: got %0d want %0d",
                       n_ferr - f0, 1 - BRK_EXP);
    end
    checks++;
    if (n_done - d0 !== 1 || n_wr - w0 !== 0) begin
      errs++; $display("FAIL brk_done: got d=%0d w=%0d want d=1 w=0",
                       n_done - d0, n_wr - w0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL brk_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int w0 = n_wr;
    cfg(4'd8, 0, 0, 0);
    send(8'h5A, 8, 0, 0, 1, 1);
    send(8'hC3, 8, 0, 0, 1, 1);
    idle(4);
    checks++;
    if (n_wr - w0 !== 2) begin
      errs++; $display("FAIL b2b_writes: got %0d want 2", n_wr - w0);
    end
    checks++;
    if (last_wr !== 8'hC3) begin
      errs++; $display("FAIL b2b_data: got %h want c3", last_wr);
    end
  endtask

  task automatic test_tick_div;
    int w0 = n_wr;
    cfg(4'd8, 0, 0, 0);
    half_rate = 1'b1;
    bc = 32;
    send(8'h69, 8, 0, 0, 1, 1);
    idle(8);
    half_rate = 1'b0;
    bc = 16;
    checks++;
    if (n_wr - w0 !== 1 || last_wr !== 8'h69) begin
      errs++; $display("FAIL tickdiv: got n=%0d d=%h want n=1 d=69",
                       n_wr - w0, last_wr);
    end
  endtask

  initial begin
    @(posedge PCLK);
    #1;
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_rxen_drop();
    test_break();
    test_back_to_back();
    test_tick_div();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
